// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Issuing side of the 16-bit ALU interface. Accepts one instruction per
//   valid/ready handshake, decodes the opcode to the ALU control code, reads
//   both source operands from the register file, drives the ALU, waits out its
//   registered latency, then writes the result back or resolves a BNE.
//
//   Sequence: IDLE -> RD -> EX -> WT -> WB -> IDLE (one instruction per 5 cycles).
//
//   Optional feature macro: SLT_EMU_EN
//     defined   : SLT writes the signed a<b compare, computed locally in WT
//     undefined : SLT writes the ALU result unchanged
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   instr_valid/instr/      instruction handshake; instr = {op, rd, rs, rt}
//   instr_ready
//   rs_addr, rt_addr        register-file read addresses
//   rf_rdata1, rf_rdata2    register-file read data (one cycle after address)
//   alu_a, alu_b,           ALU operands, control code and carry-in
//   alu_con, alu_cin
//   alu_result, alu_cout    ALU outputs (registered inside the ALU)
//   wr_en/wr_addr/wr_data   register-file write-back (wr_en is a 1-cycle pulse)
//   br_valid, br_taken      BNE resolution pulse and outcome
//   illegal                 1-cycle pulse on an undefined opcode
module alu_sequencer #(
  parameter int W  = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  input  logic [15:0]   instr,
  output logic          instr_ready,
  output logic [AW-1:0] rs_addr,
  output logic [AW-1:0] rt_addr,
  input  logic [W-1:0]  rf_rdata1,
  input  logic [W-1:0]  rf_rdata2,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [2:0]    alu_con,
  output logic          alu_cin,
  input  logic [W-1:0]  alu_result,
  input  logic          alu_cout,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [W-1:0]  wr_data,
  output logic          br_valid,
  output logic          br_taken,
  output logic          illegal
);

  typedef enum logic [2:0] {IDLE, RD, EX, WT, WB} state_t;

  state_t state_reg, state_next;

  logic [AW-1:0] rs_addr_reg, rt_addr_reg, rd_reg, wr_addr_reg;
  logic [W-1:0]  a_hold_reg, b_hold_reg, wr_data_reg;
  logic [2:0]    con_reg;
  logic          cin_reg, carry_reg;
  logic          is_bne_reg, is_add_reg;
  logic          wr_en_reg, br_valid_reg, br_taken_reg, illegal_reg;
`ifdef SLT_EMU_EN
  logic          is_slt_reg;
`endif

  logic [3:0]    op;
  logic          transfer;
  logic          dec_legal, dec_cin, dec_add;
  logic [2:0]    dec_con;
  logic [W-1:0]  result_sel;

  assign op          = instr[15:12];
  assign instr_ready = (state_reg == IDLE);
  assign transfer    = instr_valid && instr_ready;

  // Opcode decode. ADC takes the carry flag left by the last ADD/ADC; the flag
  // is always settled here because the previous instruction finished in WT.
  always_comb begin
    dec_legal = 1'b1;
    dec_con   = 3'b000;
    dec_cin   = 1'b0;
    dec_add   = 1'b0;
    case (op)
      4'd0: dec_con = 3'b000;
      4'd1: dec_con = 3'b001;
      4'd2: begin dec_con = 3'b010; dec_add = 1'b1; end
      4'd5: begin dec_con = 3'b010; dec_add = 1'b1; dec_cin = carry_reg; end
      4'd3: dec_con = 3'b011;
      4'd4: dec_con = 3'b011;
      4'd7: dec_con = 3'b111;
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (transfer && dec_legal) state_next = RD;
      RD:   state_next = EX;
      EX:   state_next = WT;
      WT:   state_next = WB;
      WB:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Value written back at the end of WT.
`ifdef SLT_EMU_EN
  always_comb begin
    result_sel = alu_result;
    if (is_slt_reg)
      result_sel = {{(W-1){1'b0}}, ($signed(a_hold_reg) < $signed(b_hold_reg))};
  end
`else
  assign result_sel = alu_result;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      rs_addr_reg  <= '0;
      rt_addr_reg  <= '0;
      rd_reg       <= '0;
      wr_addr_reg  <= '0;
      a_hold_reg   <= '0;
      b_hold_reg   <= '0;
      wr_data_reg  <= '0;
      con_reg      <= '0;
      cin_reg      <= 1'b0;
      carry_reg    <= 1'b0;
      is_bne_reg   <= 1'b0;
      is_add_reg   <= 1'b0;
      wr_en_reg    <= 1'b0;
      br_valid_reg <= 1'b0;
      br_taken_reg <= 1'b0;
      illegal_reg  <= 1'b0;
`ifdef SLT_EMU_EN
      is_slt_reg   <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      wr_en_reg    <= 1'b0;
      br_valid_reg <= 1'b0;
      br_taken_reg <= 1'b0;
      illegal_reg  <= 1'b0;

      if (transfer) begin
        illegal_reg <= ~dec_legal;
        // Illegal ops never reach RD, so the read addresses and ALU controls
        // keep whatever the last legal instruction left there.
        if (dec_legal) begin
          rs_addr_reg <= instr[7:4];
          rt_addr_reg <= instr[3:0];
          rd_reg      <= instr[11:8];
          con_reg     <= dec_con;
          cin_reg     <= dec_cin;
          is_bne_reg  <= (op == 4'd4);
          is_add_reg  <= dec_add;
`ifdef SLT_EMU_EN
          is_slt_reg  <= (op == 4'd7);
`endif
        end
      end

      // Operands arrive live from the register file in EX; keep a copy so the
      // ALU inputs stay stable through WT.
      if (state_reg == EX) begin
        a_hold_reg <= rf_rdata1;
        b_hold_reg <= rf_rdata2;
      end

      if (state_reg == WT) begin
        if (is_add_reg) carry_reg <= alu_cout;
        wr_en_reg    <= ~is_bne_reg;
        br_valid_reg <= is_bne_reg;
        br_taken_reg <= is_bne_reg && (alu_result != '0);
        if (!is_bne_reg) begin
          wr_addr_reg <= rd_reg;
          wr_data_reg <= result_sel;
        end
      end
    end
  end

  assign rs_addr  = rs_addr_reg;
  assign rt_addr  = rt_addr_reg;
  assign alu_a    = (state_reg == EX) ? rf_rdata1 : a_hold_reg;
  assign alu_b    = (state_reg == EX) ? rf_rdata2 : b_hold_reg;
  assign alu_con  = con_reg;
  assign alu_cin  = cin_reg;
  assign wr_en    = wr_en_reg;
  assign wr_addr  = wr_addr_reg;
  assign wr_data  = wr_data_reg;
  assign br_valid = br_valid_reg;
  assign br_taken = br_taken_reg;
  assign illegal  = illegal_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'h0;
  logic        instr_ready;
  logic [3:0]  rs_addr, rt_addr;
  logic [15:0] rf_rdata1 = 16'h0, rf_rdata2 = 16'h0;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_con;
  logic        alu_cin;
  logic [15:0] alu_result = 16'h0;
  logic        alu_cout = 1'b0;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        br_valid, br_taken, illegal;

  alu_sequencer #(.W(16), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_con(alu_con), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .br_valid(br_valid), .br_taken(br_taken), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: registered read, write on wr_en, bench pokes.
  logic [15:0] regs [16];
  logic        poke_en = 1'b0;
  logic [3:0]  poke_addr = 4'h0;
  logic [15:0] poke_data = 16'h0;
  always @(posedge clk) begin
    rf_rdata1 <= regs[rs_addr];
    rf_rdata2 <= regs[rt_addr];
    if (wr_en) regs[wr_addr] <= wr_data;
    if (poke_en) regs[poke_addr] <= poke_data;
  end

  // ALU model: result registered on posedge.
  logic [16:0] sum17;
  always @(posedge clk) begin
    sum17 = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, alu_cin};
    case (alu_con)
      3'b000: begin alu_result <= alu_a & alu_b; alu_cout <= 1'b0; end
      3'b001: begin alu_result <= alu_a | alu_b; alu_cout <= 1'b0; end
      3'b010: begin alu_result <= sum17[15:0];   alu_cout <= sum17[16]; end
      3'b011: begin alu_result <= alu_a - alu_b; alu_cout <= 1'b0; end
      default: begin alu_result <= 16'h0;        alu_cout <= 1'b0; end
    endcase
  end

  typedef struct {
    int          kind;   // 0 write-back, 1 branch, 2 illegal
    logic [3:0]  addr;
    logic [15:0] data;
    logic        taken;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: every output pulse is matched against the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && (wr_en || br_valid || illegal)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {29'h0, wr_en, br_valid, illegal}, 32'h0);
      end else begin
        e = sb.pop_front();
        $display("txn cyc=%0d wr_en=%0b addr=%0d data=0x%04h br_valid=%0b taken=%0b illegal=%0b",
                 cyc, wr_en, wr_addr, wr_data, br_valid, br_taken, illegal);
        chk("pulse_kind", {29'h0, wr_en, br_valid, illegal},
            (e.kind == 0) ? 32'h4 : (e.kind == 1) ? 32'h2 : 32'h1);
        chk("latency_cycle", cyc, e.cyc);
        if (e.kind == 0) begin
          chk("wr_addr", {28'h0, wr_addr}, {28'h0, e.addr});
          chk("wr_data", {16'h0, wr_data}, {16'h0, e.data});
        end else if (e.kind == 1) begin
          chk("br_taken", {31'h0, br_taken}, {31'h0, e.taken});
        end
      end
    end
  end

  task automatic poke(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  // Offer one instruction; the expectation is stamped with the cycle of its pulse.
  task automatic issue(input logic [15:0] ins, input int kind, input logic [3:0] a,
                       input logic [15:0] d, input logic tk, input bit push);
    exp_t e;
    bit got;
    got = 1'b0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr = ins;
    for (int i = 0; i < 50; i++) begin
      if (instr_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) begin
      chk("ready_timeout", 32'h0, 32'h1);
    end else begin
      e.kind = kind; e.addr = a; e.data = d; e.taken = tk;
      e.cyc = cyc + ((kind == 2) ? 1 : 4);
      if (push) sb.push_back(e);
      @(posedge clk);
    end
    #1 instr_valid = 1'b0;
  endtask

  // Called right after issue(): advances to EX and checks ALU drive.
  task automatic ex_check(input string nm, input logic [2:0] con, input logic cin,
                          input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    @(negedge clk);
    chk({nm, "_con"}, {29'h0, alu_con}, {29'h0, con});
    chk({nm, "_cin"}, {31'h0, alu_cin}, {31'h0, cin});
    chk({nm, "_a"}, {16'h0, alu_a}, {16'h0, a});
    chk({nm, "_b"}, {16'h0, alu_b}, {16'h0, b});
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_timeout", sb.size(), 32'h0);
  endtask

  logic [15:0] slt_exp;
  logic [15:0] b2b_list [3];
  int tcyc [3];
  int acc;

  initial begin
`ifdef SLT_EMU_EN
    slt_exp = 16'h0001;
`else
    slt_exp = 16'h0000;
`endif
    for (int i = 0; i < 16; i++) regs[i] = 16'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_instr_ready", {31'h0, instr_ready}, 32'h1);
    chk("rst_outputs", {alu_a, 3'b0, alu_con, alu_cin, wr_en, br_valid, br_taken, illegal, 1'b0},
        32'h0);
    rst_n = 1'b1;

    // ADD r3,r1,r2: 5 + 7 = 0x000C
    poke(4'd1, 16'h0005); poke(4'd2, 16'h0007);
    issue(16'h2312, 0, 4'd3, 16'h000C, 1'b0, 1'b1);
    ex_check("add", 3'b010, 1'b0, 16'h0005, 16'h0007);
    drain();

    // ADD wraps to 0 with carry, then ADC 1+1+1 = 3, then ADC 1+1+0 = 2
    poke(4'd1, 16'hFFFF); poke(4'd2, 16'h0001);
    issue(16'h2412, 0, 4'd4, 16'h0000, 1'b0, 1'b1);
    drain();
    poke(4'd1, 16'h0001); poke(4'd2, 16'h0001);
    issue(16'h5512, 0, 4'd5, 16'h0003, 1'b0, 1'b1);
    ex_check("adc1", 3'b010, 1'b1, 16'h0001, 16'h0001);
    drain();
    issue(16'h5512, 0, 4'd5, 16'h0002, 1'b0, 1'b1);
    ex_check("adc2", 3'b010, 1'b0, 16'h0001, 16'h0001);
    drain();

    // BNE equal / not equal
    poke(4'd1, 16'h1234); poke(4'd2, 16'h1234);
    issue(16'h4012, 1, 4'd0, 16'h0000, 1'b0, 1'b1);
    drain();
    poke(4'd2, 16'h1235);
    issue(16'h4012, 1, 4'd0, 16'h0000, 1'b1, 1'b1);
    drain();

    // AND / OR / SUB
    poke(4'd1, 16'hF0F0); poke(4'd2, 16'hFF00);
    issue(16'h0612, 0, 4'd6, 16'hF000, 1'b0, 1'b1);
    drain();
    issue(16'h1712, 0, 4'd7, 16'hFFF0, 1'b0, 1'b1);
    drain();
    poke(4'd1, 16'h0010); poke(4'd2, 16'h0003);
    issue(16'h3812, 0, 4'd8, 16'h000D, 1'b0, 1'b1);
    ex_check("sub", 3'b011, 1'b0, 16'h0010, 16'h0003);
    drain();

    // Illegal opcodes: single pulse, stays ready
    issue(16'hF123, 2, 4'd0, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    chk("illegal_ready", {31'h0, instr_ready}, 32'h1);
    drain();
    issue(16'h6123, 2, 4'd0, 16'h0000, 1'b0, 1'b1);
    drain();

    // SLT -1 < 1
    poke(4'd1, 16'hFFFF); poke(4'd2, 16'h0001);
    issue(16'h7912, 0, 4'd9, slt_exp, 1'b0, 1'b1);
    ex_check("slt", 3'b111, 1'b0, 16'hFFFF, 16'h0001);
    drain();

    // rd = 0 is an ordinary register: ADD r0 = 2+3, then OR r10,r0,r0
    poke(4'd1, 16'h0002); poke(4'd2, 16'h0003);
    issue(16'h2012, 0, 4'd0, 16'h0005, 1'b0, 1'b1);
    drain();
    issue(16'h1A00, 0, 4'd10, 16'h0005, 1'b0, 1'b1);
    drain();

    // instr_valid held across three ANDs: accepts 5 cycles apart
    poke(4'd1, 16'h00FF); poke(4'd2, 16'h0F0F);
    b2b_list[0] = 16'h0A12; b2b_list[1] = 16'h0B12; b2b_list[2] = 16'h0C12;
    acc = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr = b2b_list[0];
    for (int i = 0; i < 40 && acc < 3; i++) begin
      if (instr_ready) begin
        exp_t e;
        tcyc[acc] = cyc;
        e.kind = 0; e.addr = b2b_list[acc][11:8]; e.data = 16'h000F; e.taken = 1'b0;
        e.cyc = cyc + 4;
        sb.push_back(e);
        acc++;
        @(posedge clk);
        #1;
        if (acc < 3) instr = b2b_list[acc];
        else instr_valid = 1'b0;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("b2b_accepted", acc, 32'd3);
    chk("b2b_gap1", tcyc[1] - tcyc[0], 32'd5);
    chk("b2b_gap2", tcyc[2] - tcyc[1], 32'd5);
    drain();

    // Reset in EX drops the instruction
    poke(4'd1, 16'h0005); poke(4'd2, 16'h0007);
    issue(16'h2D12, 0, 4'd13, 16'h000C, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_instr_ready", {31'h0, instr_ready}, 32'h1);
    chk("midrst_alu", {alu_a, 3'b0, alu_con, alu_cin, 3'b0}, 32'h0);
    chk("midrst_addr", {24'h0, rs_addr, rt_addr}, 32'h0);
    chk("midrst_pulses", {28'h0, wr_en, br_valid, br_taken, illegal}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_no_write", {16'h0, regs[13]}, 32'h0);

    // Carry flag cleared by reset: ADC 1+1 = 2
    poke(4'd1, 16'h0001); poke(4'd2, 16'h0001);
    issue(16'h5E12, 0, 4'd14, 16'h0002, 1'b0, 1'b1);
    drain();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
